// File: rtl/pwm_shadow_ctrl.sv
// pwm_shadow_ctrl
//   Register-write front end for a 16-channel PWM output stage.
//   Output-enable writes (0x00/0x01) apply immediately. PWM-enable (0x02/0x03)
//   and duty (0x04) writes land in shadow registers and are committed together
//   at the next PWM period boundary so a period is never cut mid-way.
//   Owns the clock prescaler, the 8-bit PWM counter and the registered output bus.
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   wr_valid/wr_ready     write handshake (accepted when both high at an edge)
//   wr_addr[6:0]          register address
//   wr_data[7:0]          register data
//   out[15:0]             registered channel outputs, bit i = channel i
//   active_duty[7:0]      duty value currently in effect
//   pending               shadow holds values not yet committed
//   period_start          one-cycle pulse while the counter first holds 0
module pwm_shadow_ctrl #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic [15:0] out,
  output logic [7:0]  active_duty,
  output logic        pending,
  output logic        period_start
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  typedef enum logic {IDLE, PEND} state_t;
  state_t state, state_next;

  logic [PW-1:0] presc;
  logic [7:0]    pwm_cnt;
  logic          tick, boundary, accept, shadow_wr, commit, pwm_sig;
  logic [15:0]   en_out, en_pwm, sh_en_pwm;
  logic [7:0]    duty, sh_duty;

  assign tick      = (presc == PRE_MAX);
  assign boundary  = tick & (pwm_cnt == 8'hFF);
  assign accept    = wr_valid & wr_ready;
  assign shadow_wr = accept & ((wr_addr == 7'h02) | (wr_addr == 7'h03) | (wr_addr == 7'h04));
  assign commit    = (state == PEND) & boundary;

  // Full duty is forced high so 0xFF does not drop out on the last count.
  assign pwm_sig     = (duty == 8'hFF) | (pwm_cnt < duty);
  assign active_duty = duty;

  // Prescaler and period counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      presc   <= '0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      presc   <= presc + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM: next state. No write can be accepted in the commit cycle, so a
  // commit always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (shadow_wr) state_next = PEND;
      PEND:    if (boundary)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs. Stalling the commit cycle keeps a concurrent write from
  // racing the shadow->active copy; it lands in the fresh shadow next cycle.
  always_comb begin
    pending  = (state == PEND);
    wr_ready = !((state == PEND) && boundary);
  end

  // Active and shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out    <= '0;
      en_pwm    <= '0;
      duty      <= '0;
      sh_en_pwm <= '0;
      sh_duty   <= '0;
    end else begin
      if (commit) begin
        en_pwm <= sh_en_pwm;
        duty   <= sh_duty;
      end
      if (accept) begin
        case (wr_addr)
          7'h00:   en_out[7:0]     <= wr_data;
          7'h01:   en_out[15:8]    <= wr_data;
          7'h02:   sh_en_pwm[7:0]  <= wr_data;
          7'h03:   sh_en_pwm[15:8] <= wr_data;
          7'h04:   sh_duty         <= wr_data;
          default: ;
        endcase
      end
    end
  end

  // Registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= en_out & ((en_pwm & {16{pwm_sig}}) | ~en_pwm);
      period_start <= boundary;
    end
  end

endmodule

// File: tb/tb_pwm_shadow_ctrl.sv
// Testbench for pwm_shadow_ctrl: a CLK_DIV=4 instance checked every cycle
// against a cycle-count based reference model, plus a CLK_DIV=1 instance for
// the short-period case.
module tb_pwm_shadow_ctrl;

  localparam int unsigned D      = 4;
  localparam int unsigned PERIOD = 256 * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready, pending, period_start;
  logic [15:0] out;
  logic [7:0]  active_duty;

  logic        wr_valid1 = 1'b0;
  logic [6:0]  wr_addr1 = '0;
  logic [7:0]  wr_data1 = '0;
  logic        wr_ready1, pending1, period_start1;
  logic [15:0] out1;
  logic [7:0]  active_duty1;

  always #5 clk = ~clk;

  pwm_shadow_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .out(out), .active_duty(active_duty),
    .pending(pending), .period_start(period_start)
  );

  pwm_shadow_ctrl #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid1), .wr_ready(wr_ready1),
    .wr_addr(wr_addr1), .wr_data(wr_data1), .out(out1), .active_duty(active_duty1),
    .pending(pending1), .period_start(period_start1)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: counter position derived from edges since reset.
  int unsigned k;
  logic [15:0] m_en_out, m_en_pwm, s_en_pwm, m_out;
  logic [7:0]  m_duty, s_duty;
  bit          m_pend, m_ps;
  logic        last_ready;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, k);
    end
  endfunction

  function automatic void model_reset();
    k = 0;
    m_en_out = '0; m_en_pwm = '0; s_en_pwm = '0; m_out = '0;
    m_duty = '0; s_duty = '0; m_pend = 0; m_ps = 0;
  endfunction

  // One clock: entered just after a negedge, returns at the next negedge.
  task automatic step(input bit v, input logic [6:0] a, input logic [7:0] d, output bit acc);
    bit          bnd, exp_ready, sig;
    int unsigned cnt;
    logic [15:0] nxt_out;
    wr_valid = v; wr_addr = a; wr_data = d;
    #1;
    bnd       = ((k + 1) % PERIOD) == 0;
    exp_ready = !(m_pend && bnd);
    chk("wr_ready", {15'b0, wr_ready}, {15'b0, exp_ready});
    last_ready = wr_ready;
    acc = v && exp_ready;
    cnt = (k / D) % 256;
    sig = (m_duty == 8'hFF) || (cnt < int'(m_duty));
    for (int unsigned i = 0; i < 16; i++)
      nxt_out[i] = m_en_out[i] && (m_en_pwm[i] ? sig : 1'b1);
    @(posedge clk);
    m_ps = bnd;
    if (m_pend && bnd) begin
      m_en_pwm = s_en_pwm; m_duty = s_duty; m_pend = 0;
    end
    if (acc) begin
      case (a)
        7'h00: m_en_out[7:0]  = d;
        7'h01: m_en_out[15:8] = d;
        7'h02: begin s_en_pwm[7:0]  = d; m_pend = 1; end
        7'h03: begin s_en_pwm[15:8] = d; m_pend = 1; end
        7'h04: begin s_duty = d; m_pend = 1; end
        default: ;
      endcase
    end
    m_out = nxt_out;
    k++;
    #1;
    chk("out", out, m_out);
    chk("pending", {15'b0, pending}, {15'b0, m_pend});
    chk("active_duty", {8'b0, active_duty}, {8'b0, m_duty});
    chk("period_start", {15'b0, period_start}, {15'b0, m_ps});
    @(negedge clk);
  endtask

  task automatic idle();
    bit acc;
    step(0, 7'h00, 8'h00, acc);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    bit acc;
    step(1, a, d, acc);
  endtask

  // Step until the next edge is a period boundary.
  task automatic advance();
    for (int i = 0; i < int'(PERIOD) && ((k + 1) % PERIOD) != 0; i++) idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_valid = 1'b0;
    #1;
    chk("rst_out", out, 16'h0);
    chk("rst_pending", {15'b0, pending}, 16'h0);
    chk("rst_ready", {15'b0, wr_ready}, 16'h1);
    chk("rst_duty", {8'b0, active_duty}, 16'h0);
    chk("rst_out1", out1, 16'h0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp_out;
    bit          exp_pend;
  } vec_t;
  vec_t vecs[7];

  initial begin
    bit          acc, rq_v;
    logic [6:0]  rq_a;
    logic [7:0]  rq_d;
    int unsigned ones, first_ps, second_ps, ps_edge;

    vecs[0] = '{7'h00, 8'hA5, 16'h00A5, 0};
    vecs[1] = '{7'h01, 8'h3C, 16'h3CA5, 0};
    vecs[2] = '{7'h7F, 8'h12, 16'h3CA5, 0};
    vecs[3] = '{7'h05, 8'hFF, 16'h3CA5, 0};
    vecs[4] = '{7'h00, 8'h00, 16'h3C00, 0};
    vecs[5] = '{7'h01, 8'h00, 16'h0000, 0};
    vecs[6] = '{7'h00, 8'hFF, 16'h00FF, 0};

    model_reset();
    @(negedge clk);
    do_reset();

    // Idle after reset: first period_start seen right after edge 1024.
    ps_edge = 0;
    for (int i = 0; i < 1030; i++) begin
      idle();
      if (period_start && ps_edge == 0) ps_edge = k;
    end
    chk("idle_ps_edge", ps_edge[15:0], 16'd1024);

    // Immediate writes visible one clock after accept.
    foreach (vecs[i]) begin
      wr(vecs[i].addr, vecs[i].data);
      idle();
      chk("vec_out", out, vecs[i].exp_out);
      chk("vec_pend", {15'b0, pending}, {15'b0, vecs[i].exp_pend});
    end

    // Shadowed duty/pwm-enable staged mid-period.
    wr(7'h04, 8'h80); wr(7'h02, 8'hFF); wr(7'h00, 8'hFF);
    chk("stage_pend", {15'b0, pending}, 16'h1);
    chk("stage_out", {8'b0, out[7:0]}, 16'h00FF);
    advance(); idle();
    chk("commit_duty80", {8'b0, active_duty}, 16'h0080);
    ones = 0;
    for (int i = 0; i < int'(PERIOD); i++) begin idle(); ones += out[0]; end
    chk("ones_duty80", ones[15:0], 16'(PERIOD / 2));

    wr(7'h04, 8'h00); advance(); idle();
    ones = 0;
    for (int i = 0; i < int'(PERIOD); i++) begin idle(); ones += out[0]; end
    chk("ones_duty00", ones[15:0], 16'd0);

    wr(7'h04, 8'hFF); advance(); idle();
    ones = 0;
    for (int i = 0; i < int'(PERIOD); i++) begin idle(); ones += out[0]; end
    chk("ones_dutyFF", ones[15:0], 16'(PERIOD));

    // Write held across a pending boundary.
    wr(7'h04, 8'h20);
    advance();
    step(1, 7'h04, 8'h40, acc);
    chk("hold_ready_low", {15'b0, last_ready}, 16'h0);
    chk("hold_old_commit", {8'b0, active_duty}, 16'h0020);
    step(1, 7'h04, 8'h40, acc);
    chk("hold_ready_high", {15'b0, last_ready}, 16'h1);
    chk("hold_pend", {15'b0, pending}, 16'h1);
    advance(); idle();
    chk("hold_new_commit", {8'b0, active_duty}, 16'h0040);

    // Shadow write landing on an idle boundary edge commits one period later.
    advance();
    step(1, 7'h04, 8'h55, acc);
    chk("idle_bnd_ready", {15'b0, last_ready}, 16'h1);
    chk("idle_bnd_pend", {15'b0, pending}, 16'h1);
    chk("idle_bnd_duty", {8'b0, active_duty}, 16'h0040);
    advance(); idle();
    chk("idle_bnd_commit", {8'b0, active_duty}, 16'h0055);

    // Unmapped address: no change.
    wr(7'h7F, 8'h12); idle();
    chk("unmapped_pend", {15'b0, pending}, 16'h0);

    // Reset while pending.
    wr(7'h04, 8'h11);
    chk("pre_rst_pend", {15'b0, pending}, 16'h1);
    do_reset();

    // Randomized traffic with holds obeyed on stall.
    rq_v = 0; rq_a = '0; rq_d = '0;
    for (int i = 0; i < 6000; i++) begin
      if (!rq_v && $urandom_range(0, 24) == 0) begin
        rq_v = 1;
        rq_d = 8'($urandom);
        case ($urandom_range(0, 7))
          0: rq_a = 7'h00;
          1: rq_a = 7'h01;
          2: rq_a = 7'h02;
          3: rq_a = 7'h03;
          4, 7: rq_a = 7'h04;
          5: rq_a = 7'h7F;
          default: rq_a = 7'($urandom);
        endcase
      end
      step(rq_v, rq_a, rq_d, acc);
      if (acc) rq_v = 0;
    end

    // CLK_DIV=1 instance: 256-clock period.
    do_reset();
    first_ps = 0; second_ps = 0;
    for (int i = 0; i < 600; i++) begin
      idle();
      if (period_start1) begin
        if (first_ps == 0) first_ps = k;
        else if (second_ps == 0) second_ps = k;
      end
    end
    chk("div1_first_ps", first_ps[15:0], 16'd256);
    chk("div1_interval", 16'(second_ps - first_ps), 16'd256);
    chk("div1_out", out1, 16'h0);
    chk("div1_pend", {15'b0, pending1}, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
